// File: rtl/measure_clock_period_pkg.sv
// Shared types and helpers for the clock-period monitor.
// State encoding and the all-ones constant used for saturation and min-register reset.
package measure_clock_period_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    ACQ  = 2'd1,
    MEAS = 2'd2
  } state_e;

  // All-ones value of width w, used as W'(ones_w(W)) by the parameterised modules.
  function automatic logic [63:0] ones_w(input int unsigned w);
    logic [63:0] r;
    if (w >= 64) r = '1;
    else         r = (64'd1 << w) - 64'd1;
    return r;
  endfunction

endpackage

// File: rtl/measure_clock_period_if.sv
// Sample/clear inputs and measurement results of the clock-period monitor.
// The bench drives the master side; the monitor sits on the slave side.
interface measure_clock_period_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
);
  logic             i_sample;
  logic             i_clear;
  logic             o_valid;
  logic [W-1:0]     o_periodHi;
  logic [W-1:0]     o_periodLo;
  logic [W-1:0]     o_minHi;
  logic [W-1:0]     o_maxHi;
  logic [W-1:0]     o_minLo;
  logic [W-1:0]     o_maxLo;
  logic [CNT_W-1:0] o_nPeriods;
  logic             o_stuck;
  logic             o_overflow;

  modport master (
    output i_sample, i_clear,
    input  o_valid, o_periodHi, o_periodLo, o_minHi, o_maxHi,
           o_minLo, o_maxLo, o_nPeriods, o_stuck, o_overflow
  );

  modport slave (
    input  i_sample, i_clear,
    output o_valid, o_periodHi, o_periodLo, o_minHi, o_maxHi,
           o_minLo, o_maxLo, o_nPeriods, o_stuck, o_overflow
  );
endinterface

// File: rtl/measure_clock_minmax.sv
// Last/min/max tracker for one phase polarity; updates only on the record strobe.
// Min resets to all-ones and max to zero, so the first recorded value sets both.
module measure_clock_minmax
  import measure_clock_period_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clear_i,
  input  logic         rec_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] last_o,
  output logic [W-1:0] min_o,
  output logic [W-1:0] max_o
);

  localparam logic [W-1:0] MIN_RST = W'(ones_w(W));

  logic [W-1:0] last_q, last_d;
  logic [W-1:0] min_q, min_d;
  logic [W-1:0] max_q, max_d;

  always_comb begin
    last_d = last_q;
    min_d  = min_q;
    max_d  = max_q;
    if (clear_i) begin
      last_d = '0;
      min_d  = MIN_RST;
      max_d  = '0;
    end else if (rec_i) begin
      last_d = val_i;
      if (val_i < min_q) min_d = val_i;
      if (val_i > max_q) max_d = val_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_q <= '0;
      min_q  <= MIN_RST;
      max_q  <= '0;
    end else begin
      last_q <= last_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  assign last_o = last_q;
  assign min_o  = min_q;
  assign max_o  = max_q;

endmodule

// File: rtl/measure_clock_period.sv
// Measures high/low phase lengths of a clock sampled as data on the root clock.
// Lengths are reported as cycles-1; a full high-then-low period pulses o_valid.
//
//   state | meaning
//   INIT  | first cycle after reset, only captures s_q
//   ACQ   | waiting for first edge, partial phase discarded
//   MEAS  | recording every completed phase
module measure_clock_period
  import measure_clock_period_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  measure_clock_period_if.slave bus
);

  localparam logic [W-1:0]     RUN_MAX = W'(ones_w(W));
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ones_w(CNT_W));

  state_e           state_q;
  logic             s_q;
  logic [W-1:0]     run_q, run_d;
  logic             hi_seen_q;
  logic             valid_q;
  logic [CNT_W-1:0] n_q;
  logic             stuck_q;
  logic             ovf_q;

  logic edge_det;
  logic run_sat;
  logic rec_hi;
  logic rec_lo;

  always_comb begin
    edge_det = (bus.i_sample != s_q) && ((state_q == ACQ) || (state_q == MEAS));
    run_sat  = (run_q == RUN_MAX);
    rec_hi   = !bus.i_clear && (state_q == MEAS) && edge_det && s_q;
    rec_lo   = !bus.i_clear && (state_q == MEAS) && edge_det && !s_q;
    run_d    = run_q;
    if (bus.i_clear || edge_det) run_d = '0;
    else if ((state_q != INIT) && !run_sat) run_d = run_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= INIT;
      s_q       <= 1'b0;
      run_q     <= '0;
      hi_seen_q <= 1'b0;
      valid_q   <= 1'b0;
      n_q       <= '0;
      stuck_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      s_q     <= bus.i_sample;
      run_q   <= run_d;
      stuck_q <= (run_d == RUN_MAX);
      valid_q <= 1'b0;
      // Clear wins over a coincident edge, which is then simply lost.
      if (bus.i_clear) begin
        state_q   <= ACQ;
        hi_seen_q <= 1'b0;
        n_q       <= '0;
        ovf_q     <= 1'b0;
      end else begin
        case (state_q)
          INIT: state_q <= ACQ;
          ACQ: begin
            if (edge_det) state_q <= MEAS;
          end
          MEAS: begin
            if (edge_det) begin
              if (run_sat) ovf_q <= 1'b1;
              if (s_q) begin
                hi_seen_q <= 1'b1;
              end else if (hi_seen_q) begin
                valid_q <= 1'b1;
                if (n_q != CNT_MAX) n_q <= n_q + 1'b1;
              end
            end
          end
          default: state_q <= INIT;
        endcase
      end
    end
  end

  measure_clock_minmax #(.W(W)) u_hi (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .clear_i (bus.i_clear),
    .rec_i   (rec_hi),
    .val_i   (run_q),
    .last_o  (bus.o_periodHi),
    .min_o   (bus.o_minHi),
    .max_o   (bus.o_maxHi)
  );

  measure_clock_minmax #(.W(W)) u_lo (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .clear_i (bus.i_clear),
    .rec_i   (rec_lo),
    .val_i   (run_q),
    .last_o  (bus.o_periodLo),
    .min_o   (bus.o_minLo),
    .max_o   (bus.o_maxLo)
  );

  assign bus.o_valid    = valid_q;
  assign bus.o_nPeriods = n_q;
  assign bus.o_stuck    = stuck_q;
  assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_measure_clock_period.sv
// Scoreboard bench for measure_clock_period: a phase-level model pushes expected
// results when the stimulus drives a rising edge; a monitor pops them on o_valid.
module tb_measure_clock_period;

  logic clk;
  logic rst_n;

  measure_clock_period_if #(.W(8), .CNT_W(16)) bus ();
  measure_clock_period_if #(.W(8), .CNT_W(4))  bus4 ();

  measure_clock_period #(.W(8), .CNT_W(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  measure_clock_period #(.W(8), .CNT_W(4)) dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus4)
  );

  assign bus4.i_sample = bus.i_sample;
  assign bus4.i_clear  = bus.i_clear;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int  hi, lo, min_hi, max_hi, min_lo, max_lo, n, n4;
    bit  ovf;
    int  cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // phase-level reference model
  bit cur_lvl, in_meas, acq, hi_seen, ovf;
  int cur_len;
  int last_hi, last_lo, min_hi, max_hi, min_lo, max_lo, n, n4;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic model_clear();
    last_hi = 0; last_lo = 0;
    min_hi = 255; max_hi = 0; min_lo = 255; max_lo = 0;
    n = 0; n4 = 0; ovf = 0; hi_seen = 0; in_meas = 0;
  endtask

  task automatic transition();
    int rec;
    exp_t e;
    if (in_meas) begin
      rec = (cur_len - 1 > 255) ? 255 : cur_len - 1;
      if (cur_len - 1 >= 255) ovf = 1;
      if (cur_lvl) begin
        last_hi = rec;
        if (rec < min_hi) min_hi = rec;
        if (rec > max_hi) max_hi = rec;
        hi_seen = 1;
      end else begin
        last_lo = rec;
        if (rec < min_lo) min_lo = rec;
        if (rec > max_lo) max_lo = rec;
        if (hi_seen) begin
          if (n < 65535) n++;
          if (n4 < 15) n4++;
          e.hi = last_hi; e.lo = last_lo;
          e.min_hi = min_hi; e.max_hi = max_hi;
          e.min_lo = min_lo; e.max_lo = max_lo;
          e.n = n; e.n4 = n4; e.ovf = ovf;
          e.cyc = cyc + 1;
          exp_q.push_back(e);
        end
      end
    end
    if (acq) in_meas = 1;
    cur_len = 0;
  endtask

  task automatic drive(input bit v, input int ncyc);
    if (v != cur_lvl) transition();
    cur_lvl = v;
    bus.i_sample = v;
    repeat (ncyc) begin
      @(negedge clk);
      cur_len++;
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"},    bus.o_valid, 0);
    chk({tag, "_periodHi"}, bus.o_periodHi, 0);
    chk({tag, "_periodLo"}, bus.o_periodLo, 0);
    chk({tag, "_minHi"},    bus.o_minHi, 255);
    chk({tag, "_maxHi"},    bus.o_maxHi, 0);
    chk({tag, "_minLo"},    bus.o_minLo, 255);
    chk({tag, "_maxLo"},    bus.o_maxLo, 0);
    chk({tag, "_nPeriods"}, bus.o_nPeriods, 0);
    chk({tag, "_stuck"},    bus.o_stuck, 0);
    chk({tag, "_overflow"}, bus.o_overflow, 0);
    chk({tag, "_nPeriods4"}, bus4.o_nPeriods, 0);
  endtask

  task automatic pulse_clear();
    bus.i_clear = 1'b1;
    @(negedge clk);
    cur_len++;
    bus.i_clear = 1'b0;
    model_clear();
  endtask

  task automatic do_reset(input bit v);
    rst_n = 1'b0;
    bus.i_sample = v;
    cur_lvl = v;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    model_clear();
    acq = 0;
    rst_n = 1'b1;
    @(negedge clk);
    acq = 1;
    cur_len = 0;
  endtask

  always @(negedge clk) begin
    if (bus.o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", bus.o_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("valid_cycle", cyc,             mon_e.cyc);
        chk("periodHi",    bus.o_periodHi,  mon_e.hi);
        chk("periodLo",    bus.o_periodLo,  mon_e.lo);
        chk("minHi",       bus.o_minHi,     mon_e.min_hi);
        chk("maxHi",       bus.o_maxHi,     mon_e.max_hi);
        chk("minLo",       bus.o_minLo,     mon_e.min_lo);
        chk("maxLo",       bus.o_maxLo,     mon_e.max_lo);
        chk("nPeriods",    bus.o_nPeriods,  mon_e.n);
        chk("overflow",    bus.o_overflow,  mon_e.ovf);
        chk("valid4",      bus4.o_valid,    1);
        chk("nPeriods4",   bus4.o_nPeriods, mon_e.n4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 200000);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_clear  = 1'b0;
    bus.i_sample = 1'b0;
    cur_lvl = 0; cur_len = 0; acq = 0;
    model_clear();
    do_reset(1'b0);

    // hi=3 / lo=1: 4 cycles high, 2 low
    drive(1'b0, 3);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4);
      drive(1'b0, 2);
    end

    // reconfigure to hi=0 / lo=0
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 1);
      drive(1'b0, 1);
    end

    // long high phase saturates the phase counter
    drive(1'b1, 255);
    chk("stuck_before_sat", bus.o_stuck, 0);
    drive(1'b1, 1);
    chk("stuck_at_sat", bus.o_stuck, 1);
    drive(1'b1, 44);
    chk("stuck_held", bus.o_stuck, 1);
    drive(1'b0, 1);
    chk("overflow_set", bus.o_overflow, 1);
    chk("stuck_after_edge", bus.o_stuck, 0);
    chk("periodHi_sat", bus.o_periodHi, 255);
    drive(1'b0, 1);

    // clear in the middle of a high phase
    drive(1'b1, 2);
    pulse_clear();
    check_cleared("clear");
    drive(1'b1, 2);
    drive(1'b0, 2);
    drive(1'b1, 4);
    drive(1'b0, 2);
    drive(1'b1, 4);
    drive(1'b0, 2);
    drive(1'b1, 1);

    // reset while the sampled clock is high
    do_reset(1'b1);
    drive(1'b1, 2);
    drive(1'b0, 2);
    chk("nPeriods_after_reset", bus.o_nPeriods, 0);
    drive(1'b1, 4);
    drive(1'b0, 2);
    chk("nPeriods_first_hilo", bus.o_nPeriods, 0);
    drive(1'b1, 4);
    drive(1'b0, 2);
    drive(1'b1, 2);

    chk("pending_expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
